mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch and a data requester onto one memory port with a single
// outstanding transaction and a response timeout.
// Build macro ARB_ROUND_ROBIN_EN: alternate grants under contention.
// Without that macro, data always wins.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_vld,
    output logic              fetch_err,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              data_req,
    input  logic [ADDR_W-1:0] data_addr,
    output logic              data_gnt,
    output logic              data_vld,
    output logic              data_err,
    output logic [DATA_W-1:0] data_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_vld,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic       OWN_FETCH = 1'b0;
    localparam logic       OWN_DATA  = 1'b1;
    // Last wait cycle index; mem_vld on this cycle still counts as a response.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
    logic [DATA_W-1:0] data_data_q, data_data_d;
    logic              fetch_vld_q, fetch_vld_d;
    logic              fetch_err_q, fetch_err_d;
    logic              data_vld_q, data_vld_d;
    logic              data_err_q, data_err_d;
    logic              grant_s;
    logic              win_data_s;
`ifdef ARB_ROUND_ROBIN_EN
    logic              last_owner_q, last_owner_d;
`endif

    // Select the winning requester for the current cycle.
    always_comb begin
        win_data_s = 1'b0;
        if (fetch_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            win_data_s = (last_owner_q == OWN_FETCH);
`else
            win_data_s = 1'b1;
`endif
        end else begin
            win_data_s = data_req;
        end
    end

    assign grant_s = !rst && (state_q == S_IDLE) && en && (fetch_req || data_req);

    // State register and all datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_DATA;
            cnt_q        <= 8'd0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            fetch_data_q <= {DATA_W{1'b0}};
            data_data_q  <= {DATA_W{1'b0}};
            fetch_vld_q  <= 1'b0;
            fetch_err_q  <= 1'b0;
            data_vld_q   <= 1'b0;
            data_err_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= OWN_DATA;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            fetch_data_q <= fetch_data_d;
            data_data_q  <= data_data_d;
            fetch_vld_q  <= fetch_vld_d;
            fetch_err_q  <= fetch_err_d;
            data_vld_q   <= data_vld_d;
            data_err_q   <= data_err_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        fetch_data_d = fetch_data_q;
        data_data_d  = data_data_q;
        fetch_vld_d  = 1'b0;
        fetch_err_d  = 1'b0;
        data_vld_d   = 1'b0;
        data_err_d   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_s) begin
                    state_d    = S_WAIT;
                    owner_d    = win_data_s;
                    mem_addr_d = win_data_s ? data_addr : fetch_addr;
                    cnt_d      = 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_d = win_data_s;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (mem_vld) begin
                    // Response data goes straight to the owner's output register.
                    state_d = S_RESP;
                    if (owner_q == OWN_DATA) begin
                        data_data_d = mem_data;
                        data_vld_d  = 1'b1;
                    end else begin
                        fetch_data_d = mem_data;
                        fetch_vld_d  = 1'b1;
                    end
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = cnt_q + 8'd1;
                    if (owner_q == OWN_DATA) begin
                        data_data_d = {DATA_W{1'b0}};
                        data_err_d  = 1'b1;
                    end else begin
                        fetch_data_d = {DATA_W{1'b0}};
                        fetch_err_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode; grants are combinational pulses in the IDLE cycle.
    always_comb begin
        fetch_gnt = 1'b0;
        data_gnt  = 1'b0;
        if (grant_s) begin
            fetch_gnt = !win_data_s;
            data_gnt  = win_data_s;
        end else begin
            fetch_gnt = 1'b0;
            data_gnt  = 1'b0;
        end
        mem_req = !rst && (state_q == S_WAIT);
        busy    = !rst && (state_q != S_IDLE);
    end

    assign fetch_vld  = fetch_vld_q && !rst;
    assign fetch_err  = fetch_err_q && !rst;
    assign data_vld   = data_vld_q && !rst;
    assign data_err   = data_err_q && !rst;
    assign fetch_data = fetch_data_q;
    assign data_data  = data_data_q;
    assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed steps plus randomized
// transactions checked against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst, en;
    logic              fetch_req, data_req;
    logic [ADDR_W-1:0] fetch_addr, data_addr;
    logic              fetch_gnt, fetch_vld, fetch_err;
    logic              data_gnt, data_vld, data_err;
    logic [DATA_W-1:0] fetch_data, data_data;
    logic              mem_req, mem_vld, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    int total = 0;
    int bad   = 0;

    // Reference model state: delivered data per requester and last granted owner (1 = data).
    logic [DATA_W-1:0] m_fdata = '0;
    logic [DATA_W-1:0] m_ddata = '0;
    bit                m_last  = 1'b1;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .en(en),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_vld(fetch_vld), .fetch_err(fetch_err), .fetch_data(fetch_data),
        .data_req(data_req), .data_addr(data_addr), .data_gnt(data_gnt),
        .data_vld(data_vld), .data_err(data_err), .data_data(data_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_vld(mem_vld),
        .mem_data(mem_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One transaction; lat = wait cycle carrying mem_vld, lat > TIMEOUT means never.
    task automatic run_txn(input bit fr, input bit dr, input logic [ADDR_W-1:0] fa,
                           input logic [ADDR_W-1:0] da, input int lat,
                           input logic [DATA_W-1:0] md, input string tag);
        bit wd;
        bit tmo;
        int nwait;
        if (fr && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
            wd = (m_last == 1'b0);
`else
            wd = 1'b1;
`endif
        end else begin
            wd = dr;
        end
        tmo   = (lat > TIMEOUT);
        nwait = tmo ? TIMEOUT : lat;

        @(negedge clk);
        en = 1'b1; fetch_req = fr; data_req = dr; fetch_addr = fa; data_addr = da;
        mem_vld = 1'($urandom_range(0, 1)); mem_data = $urandom;
        #1;
        chk({tag, ".gnt"}, {fetch_gnt, data_gnt}, {!wd, wd});
        chk({tag, ".idle_busy"}, busy, 1'b0);
        chk({tag, ".idle_pulses"}, {fetch_vld, fetch_err, data_vld, data_err}, 4'b0000);
        m_last = wd;

        for (int k = 1; k <= nwait; k++) begin
            @(negedge clk);
            if (wd) data_req = 1'b0; else fetch_req = 1'b0;
            en       = 1'($urandom_range(0, 1));
            mem_vld  = (k == lat);
            mem_data = (k == lat) ? md : $urandom;
            #1;
            chk({tag, ".wait_req_busy"}, {mem_req, busy}, 2'b11);
            chk({tag, ".mem_addr"}, mem_addr, wd ? da : fa);
            chk({tag, ".wait_quiet"},
                {fetch_gnt, data_gnt, fetch_vld, fetch_err, data_vld, data_err}, 6'b000000);
        end

        @(negedge clk);
        mem_vld = 1'($urandom_range(0, 1)); mem_data = $urandom;
        if (tmo) begin
            fetch_req = 1'b0; data_req = 1'b0;
        end
        #1;
        if (wd) m_ddata = tmo ? '0 : md;
        else    m_fdata = tmo ? '0 : md;
        chk({tag, ".pulses"}, {fetch_vld, fetch_err, data_vld, data_err},
            tmo ? {1'b0, !wd, 1'b0, wd} : {!wd, 1'b0, wd, 1'b0});
        chk({tag, ".fetch_data"}, fetch_data, m_fdata);
        chk({tag, ".data_data"}, data_data, m_ddata);
        chk({tag, ".end_busy"}, {busy, mem_req, fetch_gnt, data_gnt}, {!tmo, 3'b000});
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; fetch_req = 1'b1; data_req = 1'b1;
        fetch_addr = 32'h0000_0011; data_addr = 32'h0000_0022;
        mem_vld = 1'b1; mem_data = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.outs", {fetch_gnt, data_gnt, fetch_vld, fetch_err, data_vld, data_err,
                         mem_req, busy}, 8'h00);
        @(negedge clk);
        rst = 1'b0; fetch_req = 1'b0; data_req = 1'b0; mem_vld = 1'b0;
        #1;
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.data", {fetch_data, data_data}, 64'h0);
        chk("rst.busy", busy, 1'b0);

        // Single fetch, mem_vld on the second cycle after the grant.
        run_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 2, 32'h1234_5678, "single_fetch");

        // Grant enable low: no grant even with both requests.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            en = 1'b0; fetch_req = 1'b1; data_req = 1'b1;
            #1;
            chk("en_low.gnt", {fetch_gnt, data_gnt, busy}, 3'b000);
        end

        // Contention held over four transactions.
        for (int i = 0; i < 4; i++)
            run_txn(1'b1, 1'b1, $urandom, $urandom, $urandom_range(1, 4), $urandom, "contend");

        // Timeout on a data transaction, then the boundary cases.
        run_txn(1'b0, 1'b1, 32'h0000_0100, 32'h0000_0200, 1, 32'hCAFE_0001, "pre_tmo");
        run_txn(1'b0, 1'b1, 32'h0, 32'h0000_0300, TIMEOUT + 1, 32'h0, "timeout");
        run_txn(1'b0, 1'b1, 32'h0, 32'h0000_0400, TIMEOUT, 32'hA5A5_5A5A, "tmo_edge");
        run_txn(1'b1, 1'b0, 32'h0000_0500, 32'h0, TIMEOUT, 32'h0F0F_F0F0, "tmo_edge_f");
        run_txn(1'b1, 1'b0, 32'h0000_0600, 32'h0, TIMEOUT + 1, 32'h0, "timeout_f");

        // Randomized transactions.
        for (int i = 0; i < 24; i++) begin
            bit fr, dr;
            fr = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!fr && !dr) fr = 1'b1;
            run_txn(fr, dr, $urandom, $urandom, $urandom_range(1, TIMEOUT + 1), $urandom, "rand");
        end

        // Reset in the middle of a wait.
        @(negedge clk);
        en = 1'b1; fetch_req = 1'b1; data_req = 1'b0; fetch_addr = 32'h0000_0777; mem_vld = 1'b0;
        #1;
        chk("rstmid.gnt", fetch_gnt, 1'b1);
        @(negedge clk);
        fetch_req = 1'b0;
        #1;
        chk("rstmid.busy_wait", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid.in_rst", {busy, mem_req}, 2'b00);
        @(negedge clk);
        rst = 1'b0; mem_vld = 1'b1; mem_data = 32'h5555_AAAA;
        #1;
        m_fdata = '0; m_ddata = '0; m_last = 1'b1;
        chk("rstmid.after", {busy, fetch_vld, fetch_err, data_vld, data_err}, 5'b00000);
        chk("rstmid.data", {fetch_data, data_data}, 64'h0);
        @(negedge clk);
        mem_vld = 1'b0;
        #1;
        chk("rstmid.idle", {busy, fetch_vld, fetch_err, data_vld, data_err}, 5'b00000);
        run_txn(1'b1, 1'b1, 32'h0000_0888, 32'h0000_0999, 1, 32'h7777_1111, "post_rst");
        run_txn(1'b1, 1'b1, 32'h0000_0AAA, 32'h0000_0BBB, 3, 32'h2222_3333, "post_rst2");

        @(negedge clk);
        fetch_req = 1'b0; data_req = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
